// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU defines for pipeline hazard control: register widths, divide FSM
// states, default divide latency and the control-output bundle.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W              = 5;
  localparam int unsigned CNT_W              = 6;
  localparam int unsigned DIV_CYCLES_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Pipeline write-enable / flush bundle driven by the hazard controller
  typedef struct packed {
    logic pc_wr;
    logic if_id_wr;
    logic id_exe_wr;
    logic exe_mem_wr;
    logic mem_wb_wr;
    logic ifid_flush;
    logic idexe_flush;
    logic exemem_flush;
    logic div_busy;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_exe_wr: 1'b1,
                                    exe_mem_wr: 1'b1, mem_wb_wr: 1'b1,
                                    ifid_flush: 1'b0, idexe_flush: 1'b0,
                                    exemem_flush: 1'b0, div_busy: 1'b0};

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use comparator: flags an ID read of the register a load in EXE will write.
module hazard_detect
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic [1:0]       ID_RegsReadSel,
  input  logic             EXE_IsLoad,
  input  logic [REG_W-1:0] EXE_Dst,
  output logic             LoadUse
);

  logic rs_hit;
  logic rt_hit;

  always_comb begin
    rs_hit  = ID_RegsReadSel[0] && (ID_rs == EXE_Dst);
    rt_hit  = ID_RegsReadSel[1] && (ID_rt == EXE_Dst);
    LoadUse = EXE_IsLoad && (EXE_Dst != REG_W'(0)) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: exception flush, dcache stall, multi-cycle divide
// stall, taken-branch flush and load-use bubble, resolved in that priority.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic [1:0]       ID_RegsReadSel,
  input  logic             EXE_IsLoad,
  input  logic [REG_W-1:0] EXE_Dst,
  input  logic             EXE_BranchTaken,
  input  logic             EXE_IsDiv,
  input  logic             MEM_Exception,
  input  logic             DCache_Busy,
  output logic             PC_Wr,
  output logic             IF_IDWr,
  output logic             ID_EXEWr,
  output logic             EXE_MEMWr,
  output logic             MEM_WBWr,
  output logic             IFID_Flush,
  output logic             IDEXE_Flush,
  output logic             EXEMEM_Flush,
  output logic             DivBusy
);

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

  div_state_t       state;
  div_state_t       state_next;
  logic [CNT_W-1:0] divcnt;
  logic [CNT_W-1:0] divcnt_next;
  logic             load_use;
  logic             div_active;
  ctrl_t            ctrl;

  hazard_detect u_detect (
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_RegsReadSel (ID_RegsReadSel),
    .EXE_IsLoad     (EXE_IsLoad),
    .EXE_Dst        (EXE_Dst),
    .LoadUse        (load_use)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      divcnt <= '0;
    end else begin
      state  <= state_next;
      divcnt <= divcnt_next;
    end
  end

  // Start cycle plus DIV_CYCLES-2 cycles in DIV gives DIV_CYCLES-1 stall cycles
  always_comb begin
    state_next  = state;
    divcnt_next = divcnt;
    case (state)
      IDLE: begin
        if (EXE_IsDiv) begin
          divcnt_next = DIV_LOAD;
          state_next  = (DIV_LOAD == '0) ? DONE : DIV;
        end
      end
      DIV: begin
        divcnt_next = (divcnt == '0) ? '0 : divcnt - CNT_W'(1);
        if (divcnt <= CNT_W'(1)) state_next = DONE;
      end
      DONE: begin
        if (!DCache_Busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (MEM_Exception) begin
      state_next  = IDLE;
      divcnt_next = '0;
    end
  end

  always_comb begin
    div_active = ((state == IDLE) && EXE_IsDiv) || (state == DIV);
    ctrl       = CTRL_NORMAL;
    if (!rst) begin
      ctrl             = '0;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idexe_flush  = 1'b1;
      ctrl.exemem_flush = 1'b1;
    end else if (MEM_Exception) begin
      ctrl.mem_wb_wr    = 1'b0;
      ctrl.ifid_flush   = 1'b1;
      ctrl.idexe_flush  = 1'b1;
      ctrl.exemem_flush = 1'b1;
    end else if (DCache_Busy) begin
      ctrl          = '0;
      ctrl.div_busy = div_active;
    end else if (div_active) begin
      ctrl.pc_wr        = 1'b0;
      ctrl.if_id_wr     = 1'b0;
      ctrl.id_exe_wr    = 1'b0;
      ctrl.exe_mem_wr   = 1'b0;
      ctrl.exemem_flush = 1'b1;
      ctrl.div_busy     = 1'b1;
    end else if (EXE_BranchTaken) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idexe_flush = 1'b1;
    end else if (load_use) begin
      ctrl.pc_wr       = 1'b0;
      ctrl.if_id_wr    = 1'b0;
      ctrl.idexe_flush = 1'b1;
    end
  end

  assign PC_Wr        = ctrl.pc_wr;
  assign IF_IDWr      = ctrl.if_id_wr;
  assign ID_EXEWr     = ctrl.id_exe_wr;
  assign EXE_MEMWr    = ctrl.exe_mem_wr;
  assign MEM_WBWr     = ctrl.mem_wb_wr;
  assign IFID_Flush   = ctrl.ifid_flush;
  assign IDEXE_Flush  = ctrl.idexe_flush;
  assign EXEMEM_Flush = ctrl.exemem_flush;
  assign DivBusy      = ctrl.div_busy;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; output vector order is
// {PC_Wr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr, IFID_Flush, IDEXE_Flush, EXEMEM_Flush, DivBusy}.
module tb_hazard_ctrl;

  localparam logic [8:0] E_NORM = 9'b11111_000_0;
  localparam logic [8:0] E_LU   = 9'b00111_010_0;
  localparam logic [8:0] E_BR   = 9'b11111_110_0;
  localparam logic [8:0] E_DIV  = 9'b00001_001_1;
  localparam logic [8:0] E_DC   = 9'b00000_000_0;
  localparam logic [8:0] E_EXC  = 9'b11110_111_0;
  localparam logic [8:0] E_RST  = 9'b00000_111_0;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] ID_rs = '0, ID_rt = '0, EXE_Dst = '0;
  logic [1:0] ID_RegsReadSel = '0;
  logic       EXE_IsLoad = 1'b0, EXE_BranchTaken = 1'b0, EXE_IsDiv = 1'b0;
  logic       MEM_Exception = 1'b0, DCache_Busy = 1'b0;
  logic       PC_Wr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr;
  logic       IFID_Flush, IDEXE_Flush, EXEMEM_Flush, DivBusy;
  logic [8:0] obs;
  int         checks = 0;
  int         fails  = 0;

  always #5 clk = ~clk;

  assign obs = {PC_Wr, IF_IDWr, ID_EXEWr, EXE_MEMWr, MEM_WBWr,
                IFID_Flush, IDEXE_Flush, EXEMEM_Flush, DivBusy};

  hazard_ctrl #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_RegsReadSel(ID_RegsReadSel),
    .EXE_IsLoad(EXE_IsLoad), .EXE_Dst(EXE_Dst), .EXE_BranchTaken(EXE_BranchTaken),
    .EXE_IsDiv(EXE_IsDiv), .MEM_Exception(MEM_Exception), .DCache_Busy(DCache_Busy),
    .PC_Wr(PC_Wr), .IF_IDWr(IF_IDWr), .ID_EXEWr(ID_EXEWr), .EXE_MEMWr(EXE_MEMWr),
    .MEM_WBWr(MEM_WBWr), .IFID_Flush(IFID_Flush), .IDEXE_Flush(IDEXE_Flush),
    .EXEMEM_Flush(EXEMEM_Flush), .DivBusy(DivBusy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ID_rs = '0; ID_rt = '0; EXE_Dst = '0; ID_RegsReadSel = '0;
    EXE_IsLoad = 1'b0; EXE_BranchTaken = 1'b0; EXE_IsDiv = 1'b0;
    MEM_Exception = 1'b0; DCache_Busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd3; ID_rs = 5'd3; ID_RegsReadSel = 2'b01;
    #2;
    checks++;
    if (obs !== E_RST) begin fails++; $display("FAIL reset_loaduse: got %b expected %b", obs, E_RST); end
    EXE_IsDiv = 1'b1; MEM_Exception = 1'b1; DCache_Busy = 1'b1; EXE_BranchTaken = 1'b1;
    #1;
    checks++;
    if (obs !== E_RST) begin fails++; $display("FAIL reset_allin: got %b expected %b", obs, E_RST); end
    clear_inputs();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL reset_release: got %b expected %b", obs, E_NORM); end
    next_cycle();
  endtask

  task automatic test_load_use();
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd5; ID_rs = 5'd5; ID_RegsReadSel = 2'b01;
    @(negedge clk);
    checks++;
    if (obs !== E_LU) begin fails++; $display("FAIL loaduse_rs: got %b expected %b", obs, E_LU); end
    next_cycle();
    EXE_IsLoad = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL loaduse_bubble_done: got %b expected %b", obs, E_NORM); end
    next_cycle();
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd9; ID_rs = 5'd1; ID_rt = 5'd9; ID_RegsReadSel = 2'b10;
    @(negedge clk);
    checks++;
    if (obs !== E_LU) begin fails++; $display("FAIL loaduse_rt: got %b expected %b", obs, E_LU); end
    ID_RegsReadSel = 2'b01;
    #1;
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL loaduse_rt_unread: got %b expected %b", obs, E_NORM); end
    next_cycle();
    EXE_Dst = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0; ID_RegsReadSel = 2'b11;
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL loaduse_r0: got %b expected %b", obs, E_NORM); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_branch();
    EXE_BranchTaken = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_BR) begin fails++; $display("FAIL branch_only: got %b expected %b", obs, E_BR); end
    next_cycle();
    EXE_IsLoad = 1'b1; EXE_Dst = 5'd7; ID_rs = 5'd7; ID_RegsReadSel = 2'b01;
    @(negedge clk);
    checks++;
    if (obs !== E_BR) begin fails++; $display("FAIL branch_over_loaduse: got %b expected %b", obs, E_BR); end
    next_cycle();
    clear_inputs();
  endtask

  // Two back-to-back divides, the second ending in a dcache-held DONE
  task automatic test_divide_back_to_back();
    EXE_IsDiv = 1'b1;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_DIV) begin fails++; $display("FAIL div1_stall[%0d]: got %b expected %b", i, obs, E_DIV); end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL div1_done: got %b expected %b", obs, E_NORM); end
    next_cycle();
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_DIV) begin fails++; $display("FAIL div2_stall[%0d]: got %b expected %b", i, obs, E_DIV); end
      next_cycle();
    end
    DCache_Busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_DC) begin fails++; $display("FAIL done_dcache[%0d]: got %b expected %b", i, obs, E_DC); end
      next_cycle();
    end
    DCache_Busy = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL done_held: got %b expected %b", obs, E_NORM); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (obs !== E_DIV) begin fails++; $display("FAIL done_exit_restart: got %b expected %b", obs, E_DIV); end
    next_cycle();
  endtask

  // Third divide already started; exception lands when divcnt is 10
  task automatic test_exception_mid_divide();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_DIV) begin fails++; $display("FAIL div3_stall[%0d]: got %b expected %b", i, obs, E_DIV); end
      next_cycle();
    end
    MEM_Exception = 1'b1; DCache_Busy = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_EXC) begin fails++; $display("FAIL exception: got %b expected %b", obs, E_EXC); end
    next_cycle();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL exception_idle: got %b expected %b", obs, E_NORM); end
    next_cycle();
  endtask

  task automatic test_reset_mid_divide();
    EXE_IsDiv = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_DIV) begin fails++; $display("FAIL div4_start: got %b expected %b", obs, E_DIV); end
    next_cycle();
    EXE_IsDiv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== E_DIV) begin fails++; $display("FAIL div4_stall[%0d]: got %b expected %b", i, obs, E_DIV); end
      next_cycle();
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs !== E_RST) begin fails++; $display("FAIL reset_async: got %b expected %b", obs, E_RST); end
    next_cycle();
    #2 rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_NORM) begin fails++; $display("FAIL reset_abandon: got %b expected %b", obs, E_NORM); end
    next_cycle();
    EXE_IsDiv = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== E_DIV) begin fails++; $display("FAIL reset_idle_start: got %b expected %b", obs, E_DIV); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_divide_back_to_back();
    test_exception_mid_divide();
    test_reset_mid_divide();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
